conv_weight_loader: RTL and testbench
=====================================

// Module: conv_weight_loader
// PURPOSE
//  Write-side counterpart of the 11x7 conv weight read path: accepts a byte stream of kernel weights,
//  packs 77 bytes (one kernel) into a 616-bit word, writes it across the 8 weight SRAM banks (77 bits
//  each) at one address per kernel. Runs once after reset/start to fill all 32 kernels before inference.
// PARAMETERS
//  DATA_W       8   bits per weight
//  KERNEL_ELEMS 77  weights per kernel (11x7)
//  NUM_BANKS    8   SRAM banks; bank width BANK_W = KERNEL_ELEMS*DATA_W/NUM_BANKS = 77
//  NUM_KERNELS  32  kernels = SRAM depth used
//  ADR_W        5   SRAM address width (2**ADR_W >= NUM_KERNELS)
// PORTS
//  clk        in   1              clock
//  rst_b      in   1              synchronous active-low reset
//  start      in   1              begin load; ignored unless IDLE
//  in_valid   in   1              weight byte valid
//  in_data    in   DATA_W         weight byte, kernel-row-major order
//  in_ready   out  1              loader accepts byte this cycle
//  sram_me    out  1              SRAM enable, all banks
//  sram_we    out  1              SRAM write enable, all banks
//  sram_adr   out  ADR_W          SRAM address (kernel index)
//  sram_d     out  [0:NUM_BANKS*BANK_W-1]  bank k gets sram_d[BANK_W*k : BANK_W*(k+1)-1]
//  busy       out  1              high from start accept until done
//  done       out  1              one-cycle pulse after last kernel written
//  checksum   out  16             (only with CONV_WL_CHECKSUM_EN) running byte sum
// BEHAVIOUR
//  Reset (rst_b=0 at clk edge): state IDLE; in_ready=0, sram_me=0, sram_we=0, sram_adr=0, sram_d=0,
//   busy=0, done=0, byte_cnt=0, kern_cnt=0. Reset mid-load aborts: no further SRAM write issued.
//  States: IDLE -start-> FILL; FILL -77th byte accepted-> WRITE; WRITE -> FILL (kern_cnt<NUM_KERNELS-1)
//   or DONE (last kernel); DONE -> IDLE (1 cycle, done=1, busy=0 next).
//  FILL: in_ready=1; byte accepted when in_valid&in_ready; byte i of kernel lands in kernel word
//   bits [DATA_W*i : DATA_W*i+DATA_W-1] (bit 0 = MSB end, same indexing as sram_d). byte_cnt 0..76,
//   wraps to 0 on 77th accept. in_valid gaps stall FILL indefinitely; no timeout.
//  WRITE: exactly one cycle; in_ready=0; sram_me=1, sram_we=1, sram_adr=kern_cnt, sram_d=kernel word
//   (registered outputs, stable for that cycle). kern_cnt increments at exit. Bytes presented during
//   WRITE/DONE/IDLE are not consumed (in_ready=0).
//  Latency: SRAM write cycle immediately follows the clock that accepts byte 76; no data copy needed.
//  start during FILL/WRITE/DONE ignored. start held high in IDLE after done restarts a new load from kernel 0.
//  sram_me/sram_we low in all states except WRITE; sram_adr holds last value outside WRITE.
//  Total for back-to-back input: 1 + 32*(77+1) + 1 cycles from start to done pulse.
// CONFIGURATION
//  CONV_WL_CHECKSUM_EN defined: checksum port present; 16-bit wrapping sum of every accepted byte
//   (unsigned), cleared on reset and on accepted start, final value valid when done pulses.
//  Undefined: no checksum port, no adder logic.
// STRUCTURE
//  Shared package conv_pkg: DATA_W, KERNEL_ELEMS, NUM_BANKS, BANK_W, NUM_KERNELS, ADR_W constants,
//   state enum typedef (IDLE, FILL, WRITE, DONE) — shared with the weight read path.
//  One sub-module: conv_weight_packer (byte shift/insert register, byte_cnt, full flag).
//  FSM, kernel counter, SRAM port drive in top level.
// TESTING
//  1 Reset then start, stream bytes 0..76 continuously -> one write, adr=0, bank0 sram_d[0:7]=8'h00,
//    bank1 first bits = byte 9 bit 5 onward; in_ready=0 in write cycle.
//  2 Full load 32*77 bytes, value=(k*77+i)&8'hFF -> 32 writes adr 0..31 in order, done pulse at cycle
//    2498 after start, busy low after; reading SRAM model back matches packed stream.
//  3 Random in_valid gaps (50%) -> identical SRAM contents to test 2, no extra/missing writes.
//  4 rst_b=0 after 40 bytes of kernel 5 -> all outputs 0 next cycle, no write; new start reloads from adr 0.
//  5 start pulses during FILL and WRITE -> ignored, counters unaffected; in_valid high in IDLE -> no accept.
//  6 CONV_WL_CHECKSUM_EN, test-2 stream -> checksum = 16-bit sum of all 2464 bytes at done; start clears it.

Source files
------------

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants and state type for the 11x7 conv weight read/write paths
package conv_pkg;

    localparam int DATA_W       = 8;
    localparam int KERNEL_ELEMS = 77;
    localparam int NUM_BANKS    = 8;
    localparam int KERNEL_W     = KERNEL_ELEMS * DATA_W;
    localparam int BANK_W       = KERNEL_W / NUM_BANKS;
    localparam int NUM_KERNELS  = 32;
    localparam int ADR_W        = 5;
    localparam int CNT_W        = $clog2(KERNEL_ELEMS);

    localparam logic [CNT_W-1:0] LAST_ELEM   = CNT_W'(KERNEL_ELEMS - 1);
    localparam logic [ADR_W-1:0] LAST_KERNEL = ADR_W'(NUM_KERNELS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } conv_state_e;

endpackage

// File: rtl/conv_weight_packer.sv
// rtl/conv_weight_packer.sv - packs accepted weight bytes into one kernel word
module conv_weight_packer
    import conv_pkg::*;
(
    input  logic                clk,
    input  logic                rst_b,
    input  logic                clear,
    input  logic                accept,
    input  logic [DATA_W-1:0]   in_data,
    output logic [0:KERNEL_W-1] word,
    output logic                full
);

    logic [CNT_W-1:0] byte_cnt;

    assign full = accept && (byte_cnt == LAST_ELEM);

    // Shifting toward bit 0 leaves byte 0 at word[0:7] once all 77 bytes are in,
    // so the word is already in SRAM order when the last byte lands.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            word     <= '0;
            byte_cnt <= '0;
        end else begin
            if (accept) begin
                word <= {word[DATA_W:KERNEL_W-1], in_data};
            end
            if (clear) begin
                byte_cnt <= '0;
            end else if (accept) begin
                byte_cnt <= full ? '0 : byte_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_weight_loader.sv
// rtl/conv_weight_loader.sv - weight byte stream to 8-bank SRAM loader; CONV_WL_CHECKSUM_EN adds checksum
module conv_weight_loader
    import conv_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_b,
    input  logic                           start,
    input  logic                           in_valid,
    input  logic [DATA_W-1:0]              in_data,
    output logic                           in_ready,
    output logic                           sram_me,
    output logic                           sram_we,
    output logic [ADR_W-1:0]               sram_adr,
    output logic [0:NUM_BANKS*BANK_W-1]    sram_d,
    output logic                           busy,
    output logic                           done
`ifdef CONV_WL_CHECKSUM_EN
    ,
    output logic [15:0]                    checksum
`endif
);

    conv_state_e      state;
    logic [ADR_W-1:0] kern_cnt;
    logic             accept;
    logic             start_acc;
    logic             full;

    assign accept    = in_valid && in_ready;
    assign start_acc = (state == IDLE) && start;

    // The packer register drives sram_d directly; in_ready is low during WRITE so it is stable.
    conv_weight_packer u_packer (
        .clk     (clk),
        .rst_b   (rst_b),
        .clear   (start_acc),
        .accept  (accept),
        .in_data (in_data),
        .word    (sram_d),
        .full    (full)
    );

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            sram_me  <= 1'b0;
            sram_we  <= 1'b0;
            sram_adr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            kern_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= FILL;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        kern_cnt <= '0;
                    end
                end
                FILL: begin
                    if (full) begin
                        state    <= WRITE;
                        in_ready <= 1'b0;
                        sram_me  <= 1'b1;
                        sram_we  <= 1'b1;
                        sram_adr <= kern_cnt;
                    end
                end
                WRITE: begin
                    sram_me  <= 1'b0;
                    sram_we  <= 1'b0;
                    kern_cnt <= kern_cnt + 1'b1;
                    if (kern_cnt == LAST_KERNEL) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state    <= FILL;
                        in_ready <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CONV_WL_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            checksum <= '0;
        end else if (start_acc) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= checksum + 16'(in_data);
        end
    end
`endif

endmodule

// File: tb/tb_conv_weight_loader.sv
// tb/tb_conv_weight_loader.sv - self-checking bench for conv_weight_loader
module tb_conv_weight_loader;
    import conv_pkg::*;

    localparam int KW    = KERNEL_ELEMS * DATA_W;
    localparam int TOTAL = NUM_KERNELS * KERNEL_ELEMS;

    logic              clk = 1'b0;
    logic              rst_b = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              sram_me;
    logic              sram_we;
    logic [ADR_W-1:0]  sram_adr;
    logic [0:KW-1]     sram_d;
    logic              busy;
    logic              done;
`ifdef CONV_WL_CHECKSUM_EN
    logic [15:0]       checksum;
`endif

    conv_weight_loader dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .sram_me  (sram_me),
        .sram_we  (sram_we),
        .sram_adr (sram_adr),
        .sram_d   (sram_d),
        .busy     (busy),
        .done     (done)
`ifdef CONV_WL_CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADR_W-1:0] adr;
        logic [0:KW-1]    d;
    } wr_t;

    typedef struct {
        int         lo;
        logic [7:0] exp;
    } head_t;

    typedef struct {
        int gap;
        bit pulses;
        int exp_writes;
        int exp_cycles;
    } scen_t;

    wr_t           exp_q[$];
    wr_t           mon_e;
    logic [0:KW-1] mem     [NUM_KERNELS];
    logic [0:KW-1] ref_mem [NUM_KERNELS];
    logic [0:KW-1] exp_word = '0;
    logic [15:0]   exp_sum = 16'h0;
    int            n_checks = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            t0 = 0;
    int            wr_cnt = 0;
    int            done_cnt = 0;
    head_t         heads [9];
    scen_t         scens [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model and scoreboard consumer
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (sram_we === 1'b1 || sram_me === 1'b1) begin
            wr_cnt++;
            chk("write_in_ready_low", in_ready, 0);
            chk("write_me_eq_we", sram_me, sram_we);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: adr %0d with no pending kernel", sram_adr);
            end else begin
                mon_e = exp_q.pop_front();
                chk("write_adr", sram_adr, mon_e.adr);
                n_checks++;
                if (sram_d !== mon_e.d) begin
                    n_fail++;
                    $display("FAIL write_data adr %0d: got %h expected %h", sram_adr, sram_d, mon_e.d);
                end
            end
            mem[sram_adr] = sram_d;
        end
    end

    task automatic account(input int idx);
        int  i;
        int  k;
        wr_t e;
        i = idx % KERNEL_ELEMS;
        k = idx / KERNEL_ELEMS;
        exp_word[DATA_W*i +: DATA_W] = idx[7:0];
        exp_sum = exp_sum + {8'h00, idx[7:0]};
        if (i == KERNEL_ELEMS - 1) begin
            e.adr = k[ADR_W-1:0];
            e.d   = exp_word;
            exp_q.push_back(e);
            ref_mem[k] = exp_word;
        end
    endtask

    task automatic run_load(input int first, input int last, input int gap, input bit pulses, input bit do_start);
        int idx;
        int guard;
        idx   = first;
        guard = 0;
        if (do_start) begin
            @(negedge clk);
            start   = 1'b1;
            t0      = cyc;
            exp_sum = 16'h0;
            @(negedge clk);
            start = 1'b0;
            chk("busy_after_start", busy, 1);
            chk("in_ready_in_fill", in_ready, 1);
`ifdef CONV_WL_CHECKSUM_EN
            chk("checksum_cleared_by_start", checksum, 0);
`endif
        end
        while (idx < last && guard < 20000) begin
            in_valid = ($urandom_range(99) >= gap);
            in_data  = idx[7:0];
            start    = pulses && (sram_we || ($urandom_range(19) == 0));
            if (in_valid && in_ready) begin
                account(idx);
                idx++;
            end
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("load_within_budget", guard < 20000, 1);
    endtask

    task automatic wait_done(input int exp_cycles);
        int g;
        g = 0;
        while (done !== 1'b1 && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk("done_pulse_seen", done, 1);
        if (exp_cycles != 0) chk("done_latency", cyc - t0 + 1, exp_cycles);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_sram_me"}, sram_me, 0);
        chk({tag, "_sram_we"}, sram_we, 0);
        chk({tag, "_sram_adr"}, sram_adr, 0);
        chk({tag, "_sram_d_zero"}, (sram_d == '0), 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        int wr0;
        int d0;

        // first 8 bits of each bank (bank k starts at bit 77*k) and the last byte, for bytes 0..76
        heads[0] = '{0,   8'h00};
        heads[1] = '{77,  8'h21};
        heads[2] = '{154, 8'h4C};
        heads[3] = '{231, 8'h0E};
        heads[4] = '{308, 8'h62};
        heads[5] = '{385, 8'h60};
        heads[6] = '{462, 8'h4E};
        heads[7] = '{539, 8'h1A};
        heads[8] = '{608, 8'h4C};

        scens[0] = '{0,  1'b1, NUM_KERNELS, 1 + NUM_KERNELS * (KERNEL_ELEMS + 1) + 1};
        scens[1] = '{50, 1'b0, NUM_KERNELS, 0};

        rst_b = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_b = 1'b1;

        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("idle_no_accept", in_ready, 0);
        end
        in_valid = 1'b0;

        // first kernel streamed back to back, stop on the write cycle
        run_load(0, KERNEL_ELEMS, 0, 1'b0, 1'b1);
        chk("k0_write_we", sram_we, 1);
        chk("k0_write_adr", sram_adr, 0);
        chk("k0_write_in_ready", in_ready, 0);
        for (int j = 0; j < 9; j++) begin
            chk($sformatf("k0_bank_bits_%0d", heads[j].lo), sram_d[heads[j].lo +: 8], heads[j].exp);
        end

        // continue through 40 bytes of kernel 5, then abort with reset
        run_load(KERNEL_ELEMS, 5 * KERNEL_ELEMS + 40, 0, 1'b0, 1'b0);
        rst_b = 1'b0;
        @(negedge clk);
        check_idle_outputs("abort");
        chk("abort_writes_so_far", wr_cnt, 5);
        chk("abort_nothing_pending", exp_q.size(), 0);
        rst_b    = 1'b1;
        in_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("after_abort_no_accept", in_ready, 0);
        end
        in_valid = 1'b0;
        chk("after_abort_no_write", wr_cnt, 5);

        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < NUM_KERNELS; k++) mem[k] = '0;
            wr0 = wr_cnt;
            d0  = done_cnt;
            run_load(0, TOTAL, scens[s].gap, scens[s].pulses, 1'b1);
            wait_done(scens[s].exp_cycles);
            chk($sformatf("s%0d_write_count", s), wr_cnt - wr0, scens[s].exp_writes);
            chk($sformatf("s%0d_done_count", s), done_cnt - d0, 1);
            chk($sformatf("s%0d_queue_empty", s), exp_q.size(), 0);
            for (int k = 0; k < NUM_KERNELS; k++) begin
                n_checks++;
                if (mem[k] !== ref_mem[k]) begin
                    n_fail++;
                    $display("FAIL s%0d_sram_readback adr %0d: got %h expected %h", s, k, mem[k], ref_mem[k]);
                end
            end
`ifdef CONV_WL_CHECKSUM_EN
            chk($sformatf("s%0d_checksum", s), checksum, exp_sum);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got no end of test expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
